// File: rtl/hdr_pkt_drr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hdr_pkt_drr_scheduler
// Brief    : Deficit-round-robin packet scheduler driving the hdr+payload mux select.
// Revision : 1.0
// ============================================================================
module hdr_pkt_drr_scheduler #(
    parameter int S_COUNT       = 4,
    parameter int LEN_WIDTH     = 16,
    parameter int QUANTUM_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [S_COUNT-1:0]               req,
    input  logic [S_COUNT*LEN_WIDTH-1:0]     req_len,
    input  logic [S_COUNT*QUANTUM_WIDTH-1:0] cfg_quantum,
    input  logic                             hdr_fire,
    input  logic                             last_fire,
    output logic [S_COUNT-1:0]               grant,
    output logic                             grant_valid,
    output logic [$clog2(S_COUNT)-1:0]       grant_encoded,
    output logic [LEN_WIDTH-1:0]             grant_len
);

    localparam int DEF_WIDTH = ((LEN_WIDTH > QUANTUM_WIDTH) ? LEN_WIDTH : QUANTUM_WIDTH) + 1;
    localparam int SUM_WIDTH = DEF_WIDTH + 1;
    localparam int PTR_WIDTH = $clog2(S_COUNT);

    localparam logic [0:0]           ST_SCAN   = 1'b0;
    localparam logic [0:0]           ST_ACTIVE = 1'b1;
    localparam logic [PTR_WIDTH-1:0] LAST_PORT = PTR_WIDTH'(S_COUNT - 1);
    localparam logic [DEF_WIDTH-1:0] DEF_MAX   = '1;

    logic [0:0]           state_q, state_d;
    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic                 fresh_q, fresh_d;
    logic                 hdr_done_q, hdr_done_d;
    logic                 last_done_q, last_done_d;
    logic [DEF_WIDTH-1:0] deficit_q [S_COUNT];
    logic [DEF_WIDTH-1:0] deficit_d [S_COUNT];
    logic [S_COUNT-1:0]   grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [PTR_WIDTH-1:0] grant_encoded_q, grant_encoded_d;
    logic [LEN_WIDTH-1:0] grant_len_q, grant_len_d;

    logic                     cur_req;
    logic [LEN_WIDTH-1:0]     cur_len;
    logic [QUANTUM_WIDTH-1:0] cur_quantum;
    logic [DEF_WIDTH-1:0]     cur_def;
    logic [DEF_WIDTH-1:0]     eff_len;
    logic [SUM_WIDTH-1:0]     sum;
    logic [PTR_WIDTH-1:0]     ptr_inc;
    logic                     done;

    // Only the port under the pointer is ever examined, so all selects key off ptr_q.
    always_comb begin
        cur_req     = req[ptr_q];
        cur_len     = req_len[ptr_q*LEN_WIDTH +: LEN_WIDTH];
        cur_quantum = cfg_quantum[ptr_q*QUANTUM_WIDTH +: QUANTUM_WIDTH];
        cur_def     = deficit_q[ptr_q];
        eff_len     = (cur_len == '0) ? DEF_WIDTH'(1) : DEF_WIDTH'(cur_len);
        sum         = {1'b0, cur_def} + SUM_WIDTH'(cur_quantum);
        ptr_inc     = (ptr_q == LAST_PORT) ? '0 : ptr_q + 1'b1;
        done        = (hdr_done_q | hdr_fire) & (last_done_q | last_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_SCAN;
            ptr_q           <= '0;
            fresh_q         <= 1'b1;
            hdr_done_q      <= 1'b0;
            last_done_q     <= 1'b0;
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_encoded_q <= '0;
            grant_len_q     <= '0;
            for (int i = 0; i < S_COUNT; i++) deficit_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            fresh_q         <= fresh_d;
            hdr_done_q      <= hdr_done_d;
            last_done_q     <= last_done_d;
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_encoded_q <= grant_encoded_d;
            grant_len_q     <= grant_len_d;
            for (int i = 0; i < S_COUNT; i++) deficit_q[i] <= deficit_d[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        fresh_d         = fresh_q;
        hdr_done_d      = hdr_done_q;
        last_done_d     = last_done_q;
        deficit_d       = deficit_q;
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        grant_encoded_d = grant_encoded_q;
        grant_len_d     = grant_len_q;
        case (state_q)
            ST_SCAN: begin
                if (!cur_req || cur_quantum == '0) begin
                    deficit_d[ptr_q] = '0;
                    ptr_d            = ptr_inc;
                    fresh_d          = 1'b1;
                end else if (fresh_q) begin
                    deficit_d[ptr_q] = sum[DEF_WIDTH] ? DEF_MAX : sum[DEF_WIDTH-1:0];
                    fresh_d          = 1'b0;
                end else if (cur_def >= eff_len) begin
                    deficit_d[ptr_q] = cur_def - eff_len;
                    grant_d          = S_COUNT'(1) << ptr_q;
                    grant_valid_d    = 1'b1;
                    grant_encoded_d  = ptr_q;
                    grant_len_d      = cur_len;
                    state_d          = ST_ACTIVE;
                end else begin
                    ptr_d   = ptr_inc;
                    fresh_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Pointer and fresh are left alone so leftover deficit serves the next packet.
                if (done) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    hdr_done_d    = 1'b0;
                    last_done_d   = 1'b0;
                    state_d       = ST_SCAN;
                end else begin
                    hdr_done_d  = hdr_done_q | hdr_fire;
                    last_done_d = last_done_q | last_fire;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_comb begin
        grant         = grant_q;
        grant_valid   = grant_valid_q;
        grant_encoded = grant_encoded_q;
        grant_len     = grant_len_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hdr_pkt_drr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdr_pkt_drr_scheduler
// Brief    : Directed scoreboard bench for the DRR packet scheduler.
// Revision : 1.0
// ============================================================================
module tb_hdr_pkt_drr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_len = '0;
    logic [63:0] cfg_quantum = '0;
    logic        hdr_fire = 1'b0;
    logic        last_fire = 1'b0;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_encoded;
    logic [15:0] grant_len;

    hdr_pkt_drr_scheduler #(
        .S_COUNT       (4),
        .LEN_WIDTH     (16),
        .QUANTUM_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_len       (req_len),
        .cfg_quantum   (cfg_quantum),
        .hdr_fire      (hdr_fire),
        .last_fire     (last_fire),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded),
        .grant_len     (grant_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit v;
        int idx;
        int len;
    } ev_t;

    ev_t  expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_en = 1'b1;
    logic gv_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_grant(input int c, input int idx, input int len);
        ev_t e;
        e.cyc = c; e.v = 1'b1; e.idx = idx; e.len = len;
        expq.push_back(e);
    endtask

    task automatic exp_rel(input int c);
        ev_t e;
        e.cyc = c; e.v = 1'b0; e.idx = 0; e.len = 0;
        expq.push_back(e);
    endtask

    // Monitor: every grant_valid transition must match the next queued expectation.
    always @(negedge clk) begin : mon
        ev_t e;
        if (sb_en && (grant_valid !== gv_prev)) begin
            if (expq.size() == 0) begin
                chk("unexpected_event_cycle", cyc, -1);
            end else begin
                e = expq.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_kind", int'(grant_valid), int'(e.v));
                if (e.v) begin
                    chk("grant_index", int'(grant_encoded), e.idx);
                    chk("grant_len", int'(grant_len), e.len);
                    chk("grant_onehot", int'(grant), 1 << e.idx);
                end else begin
                    chk("grant_cleared", int'(grant), 0);
                end
            end
        end
        gv_prev = grant_valid;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fire(input bit h, input bit l);
        hdr_fire  = h;
        last_fire = l;
        step(1);
        hdr_fire  = 1'b0;
        last_fire = 1'b0;
    endtask

    task automatic set_port(input int i, input int q, input int len);
        cfg_quantum[i*16 +: 16] = 16'(q);
        req_len[i*16 +: 16]     = 16'(len);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req         = '0;
        hdr_fire    = 1'b0;
        last_fire   = 1'b0;
        cfg_quantum = '0;
        req_len     = '0;
        step(2);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b0, b1, w, idx, diff;

        // Reset state
        do_reset();
        chk("rst_grant", int'(grant), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant_encoded", int'(grant_encoded), 0);
        chk("rst_grant_len", int'(grant_len), 0);

        // Port 0 alone: 256 -> 156 -> 56 -> (rotate) 312 -> 212 -> 112; fire orderings
        set_port(0, 256, 100);
        req = 4'b0001;
        rst = 1'b0;
        exp_grant(cyc + 2, 0, 100);
        step(3);
        fire(1'b1, 1'b0);
        step(3);
        exp_rel(cyc + 1);
        fire(1'b0, 1'b1);
        exp_grant(cyc + 1, 0, 100);
        step(1);
        fire(1'b0, 1'b1);
        step(2);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b0);
        exp_grant(cyc + 6, 0, 100);
        step(6);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        exp_grant(cyc + 1, 0, 100);
        step(1);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        req = 4'b0000;
        step(3);

        // Disabled port 2 is skipped; an empty visit clears port 1's leftover deficit
        do_reset();
        set_port(1, 100, 100);
        set_port(2, 0, 50);
        req = 4'b0110;
        rst = 1'b0;
        exp_grant(cyc + 3, 1, 100);
        step(3);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        exp_grant(cyc + 6, 1, 100);
        step(6);
        set_port(1, 300, 100);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        exp_grant(cyc + 6, 1, 100);
        step(6);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        req = 4'b0100;
        set_port(1, 300, 400);
        step(1);
        req = 4'b0110;
        exp_grant(cyc + 10, 1, 400);
        step(10);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        req = 4'b0000;
        step(3);

        // Reset while a packet owns the grant
        do_reset();
        set_port(1, 1000, 100);
        req = 4'b0010;
        rst = 1'b0;
        exp_grant(cyc + 3, 1, 100);
        step(5);
        exp_rel(cyc + 1);
        rst = 1'b1;
        step(1);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_grant_valid", int'(grant_valid), 0);
        chk("midrst_grant_encoded", int'(grant_encoded), 0);
        chk("midrst_grant_len", int'(grant_len), 0);
        set_port(1, 100, 150);
        rst = 1'b0;
        exp_grant(cyc + 8, 1, 150);
        step(8);
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        req = 4'b0000;
        step(3);

        // Zero-length packets each cost one byte and are granted back to back
        do_reset();
        set_port(0, 65535, 0);
        req = 4'b0001;
        rst = 1'b0;
        exp_grant(cyc + 2, 0, 0);
        step(2);
        for (int i = 0; i < 3; i++) begin
            exp_rel(cyc + 1);
            fire(1'b1, 1'b1);
            exp_grant(cyc + 1, 0, 0);
            step(1);
        end
        exp_rel(cyc + 1);
        fire(1'b1, 1'b1);
        req = 4'b0000;
        step(3);

        // Two saturated ports, equal quanta, very different packet sizes
        sb_en = 1'b0;
        do_reset();
        set_port(0, 1500, 64);
        set_port(1, 1500, 1500);
        req = 4'b0011;
        rst = 1'b0;
        b0 = 0;
        b1 = 0;
        while (b0 + b1 < 30000) begin
            w = 0;
            while (grant_valid !== 1'b1 && w < 40) begin
                step(1);
                w++;
            end
            if (grant_valid !== 1'b1) begin
                chk("share_grant_timeout", w, 0);
                break;
            end
            idx = int'(grant_encoded);
            chk("share_port_in_range", int'(idx < 2), 1);
            chk("share_len", int'(grant_len), (idx == 0) ? 64 : 1500);
            if (idx == 0) b0 += 64;
            else          b1 += 1500;
            fire(1'b1, 1'b1);
        end
        req = 4'b0000;
        step(3);
        diff = (b0 > b1) ? b0 - b1 : b1 - b0;
        $display("share: port0 %0d bytes, port1 %0d bytes", b0, b1);
        chk("share_balance_within_3000", int'(diff <= 3000), 1);
        sb_en = 1'b1;

        chk("scoreboard_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
